// File: rtl/idex_elastic_reg.sv
// rtl/idex_elastic_reg.sv - ID/EX pipeline register with valid/ready handshake, optional skid entry, flush and stall counter
module idex_elastic_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2,
   parameter int M_W    = 3,
   parameter int EX_W   = 4,
   parameter int SKID   = 1,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WB_W-1:0]   in_wb,
   input  logic [M_W-1:0]    in_m,
   input  logic [EX_W-1:0]   in_ex,
   input  logic [DATA_W-1:0] in_address,
   input  logic [DATA_W-1:0] in_readdata1,
   input  logic [DATA_W-1:0] in_readdata2,
   input  logic [DATA_W-1:0] in_extended,
   input  logic [REG_W-1:0]  in_rt,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WB_W-1:0]   out_wb,
   output logic [M_W-1:0]    out_m,
   output logic [EX_W-1:0]   out_ex,
   output logic [DATA_W-1:0] out_address,
   output logic [DATA_W-1:0] out_readdata1,
   output logic [DATA_W-1:0] out_readdata2,
   output logic [DATA_W-1:0] out_extended,
   output logic [REG_W-1:0]  out_rt,
   output logic [REG_W-1:0]  out_rd,
   input  logic              clr_cnt,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int PW = WB_W + M_W + EX_W + 4*DATA_W + 2*REG_W;

   logic [PW-1:0]     in_beat;
   logic [PW-1:0]     main_q;
   logic [PW-1:0]     skid_q;
   logic              main_valid;
   logic              skid_valid;
   logic              ready_q;
   logic              accept;
   logic              main_load;
   logic [WB_W-1:0]   q_wb;
   logic [M_W-1:0]    q_m;
   logic [EX_W-1:0]   q_ex;

   assign in_beat = {in_wb, in_m, in_ex, in_address, in_readdata1, in_readdata2,
                     in_extended, in_rt, in_rd};

   // Main can take a new beat whenever it is empty or its current beat leaves this edge.
   assign main_load = !main_valid || out_ready;
   assign in_ready  = (SKID != 0) ? ready_q : main_load;
   assign accept    = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else if (flush) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         ready_q    <= 1'b1;
      end else if (main_load) begin
         if (skid_valid) begin
            main_q     <= skid_q;
            main_valid <= 1'b1;
            skid_valid <= 1'b0;
            ready_q    <= 1'b1;
         end else begin
            main_valid <= accept;
            if (accept) begin
               main_q <= in_beat;
            end
         end
      end else if (accept && (SKID != 0)) begin
         skid_q     <= in_beat;
         skid_valid <= 1'b1;
         ready_q    <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (clr_cnt) begin
         stall_cnt <= '0;
      end else if (main_valid && !out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign {q_wb, q_m, q_ex, out_address, out_readdata1, out_readdata2,
           out_extended, out_rt, out_rd} = main_q;

   // Control groups read as a bubble whenever nothing valid is presented.
   assign out_valid = main_valid;
   assign out_wb    = main_valid ? q_wb : '0;
   assign out_m     = main_valid ? q_m  : '0;
   assign out_ex    = main_valid ? q_ex : '0;

endmodule

// File: tb/tb_idex_elastic_reg.sv
// tb/tb_idex_elastic_reg.sv - scoreboard bench: two SKID=1 instances (CNT_W=16 and 3) and one SKID=0 instance
module tb_idex_elastic_reg;

   typedef struct packed {
      logic [1:0]  wb;
      logic [2:0]  m;
      logic [3:0]  ex;
      logic [31:0] addr;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ext;
      logic [4:0]  rt;
      logic [4:0]  rd;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   beat_t       cur;
   logic        iv[3];
   logic        irdy[3];
   logic        ov[3];
   logic        ordy[3];
   logic        clr[3];
   logic [1:0]  o_wb[3];
   logic [2:0]  o_m[3];
   logic [3:0]  o_ex[3];
   logic [31:0] o_addr[3];
   logic [31:0] o_rd1[3];
   logic [31:0] o_rd2[3];
   logic [31:0] o_ext[3];
   logic [4:0]  o_rt[3];
   logic [4:0]  o_rd[3];
   logic [15:0] cnt_a;
   logic [15:0] cnt_b;
   logic [2:0]  cnt_c;

   beat_t exp_q[3][$];
   int    exp_cnt[3];
   bit    pushed[3];
   int    n_chk = 0;
   int    n_fail = 0;

   always #5 clk = ~clk;

   idex_elastic_reg #(.SKID(1), .CNT_W(16)) dut_a (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
      .in_wb(cur.wb), .in_m(cur.m), .in_ex(cur.ex), .in_address(cur.addr),
      .in_readdata1(cur.rd1), .in_readdata2(cur.rd2), .in_extended(cur.ext),
      .in_rt(cur.rt), .in_rd(cur.rd), .flush(flush),
      .out_valid(ov[0]), .out_ready(ordy[0]), .out_wb(o_wb[0]), .out_m(o_m[0]),
      .out_ex(o_ex[0]), .out_address(o_addr[0]), .out_readdata1(o_rd1[0]),
      .out_readdata2(o_rd2[0]), .out_extended(o_ext[0]), .out_rt(o_rt[0]),
      .out_rd(o_rd[0]), .clr_cnt(clr[0]), .stall_cnt(cnt_a));

   idex_elastic_reg #(.SKID(0), .CNT_W(16)) dut_b (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
      .in_wb(cur.wb), .in_m(cur.m), .in_ex(cur.ex), .in_address(cur.addr),
      .in_readdata1(cur.rd1), .in_readdata2(cur.rd2), .in_extended(cur.ext),
      .in_rt(cur.rt), .in_rd(cur.rd), .flush(flush),
      .out_valid(ov[1]), .out_ready(ordy[1]), .out_wb(o_wb[1]), .out_m(o_m[1]),
      .out_ex(o_ex[1]), .out_address(o_addr[1]), .out_readdata1(o_rd1[1]),
      .out_readdata2(o_rd2[1]), .out_extended(o_ext[1]), .out_rt(o_rt[1]),
      .out_rd(o_rd[1]), .clr_cnt(clr[1]), .stall_cnt(cnt_b));

   idex_elastic_reg #(.SKID(1), .CNT_W(3)) dut_c (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
      .in_wb(cur.wb), .in_m(cur.m), .in_ex(cur.ex), .in_address(cur.addr),
      .in_readdata1(cur.rd1), .in_readdata2(cur.rd2), .in_extended(cur.ext),
      .in_rt(cur.rt), .in_rd(cur.rd), .flush(flush),
      .out_valid(ov[2]), .out_ready(ordy[2]), .out_wb(o_wb[2]), .out_m(o_m[2]),
      .out_ex(o_ex[2]), .out_address(o_addr[2]), .out_readdata1(o_rd1[2]),
      .out_readdata2(o_rd2[2]), .out_extended(o_ext[2]), .out_rt(o_rt[2]),
      .out_rd(o_rd[2]), .clr_cnt(clr[2]), .stall_cnt(cnt_c));

   task automatic chk(input string nm, input logic [159:0] a, input logic [159:0] e);
      n_chk++;
      if (a !== e) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, a, e);
      end
   endtask

   function automatic beat_t out_beat(input int j);
      return '{wb: o_wb[j], m: o_m[j], ex: o_ex[j], addr: o_addr[j], rd1: o_rd1[j],
               rd2: o_rd2[j], ext: o_ext[j], rt: o_rt[j], rd: o_rd[j]};
   endfunction

   function automatic int cnt_of(input int j);
      case (j)
         0:       return int'(cnt_a);
         1:       return int'(cnt_b);
         default: return int'(cnt_c);
      endcase
   endfunction

   function automatic beat_t rnd_beat(input logic [31:0] a);
      beat_t b;
      b.wb = 2'($urandom); b.m = 3'($urandom); b.ex = 4'($urandom);
      b.addr = a; b.rd1 = $urandom; b.rd2 = $urandom; b.ext = $urandom;
      b.rt = 5'($urandom); b.rd = 5'($urandom);
      return b;
   endfunction

   // Inputs are set just after negedge; acceptance is recorded 1 time unit later.
   task automatic step();
      #1;
      for (int j = 0; j < 3; j++) begin
         pushed[j] = iv[j] && irdy[j] && !flush;
         if (pushed[j]) exp_q[j].push_back(cur);
      end
      @(negedge clk);
   endtask

   task automatic send(input int j, input logic [31:0] a, input bit tog);
      cur = rnd_beat(a);
      iv[j] = 1'b1;
      for (int k = 0; k < 20; k++) begin
         if (tog) ordy[j] = !ordy[j];
         step();
         if (pushed[j]) return;
      end
      chk("accept_timeout", 160'(0), 160'(1));
   endtask

   task automatic chk_reset();
      for (int j = 0; j < 3; j++) begin
         chk("rst_out_valid", 160'(ov[j]), 160'(0));
         chk("rst_in_ready", 160'(irdy[j]), 160'(1));
         chk("rst_outputs", 160'(out_beat(j)), 160'(0));
         chk("rst_stall_cnt", 160'(cnt_of(j)), 160'(0));
      end
   endtask

   // Monitor: model of held beats is the expected queue; compares just before each edge.
   initial begin
      int    held;
      int    cmax;
      beat_t exp_b;
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            for (int j = 0; j < 3; j++) begin
               exp_q[j].delete();
               exp_cnt[j] = 0;
            end
         end else begin
            for (int j = 0; j < 3; j++) begin
               held = exp_q[j].size() - (pushed[j] ? 1 : 0);
               chk("out_valid", 160'(ov[j]), 160'(held > 0));
               if (j == 1) chk("in_ready_comb", 160'(irdy[j]), 160'(!ov[j] || ordy[j]));
               else        chk("in_ready_skid", 160'(irdy[j]), 160'(held < 2));
               if (!ov[j]) chk("bubble_ctrl", 160'({o_wb[j], o_m[j], o_ex[j]}), 160'(0));
               chk("stall_cnt", 160'(cnt_of(j)), 160'(exp_cnt[j]));
               if (ov[j] && ordy[j] && exp_q[j].size() > 0) begin
                  exp_b = exp_q[j].pop_front();
                  chk("out_beat", 160'(out_beat(j)), 160'(exp_b));
               end
               if (flush) exp_q[j].delete();
               cmax = (j == 2) ? 7 : 65535;
               if (clr[j]) exp_cnt[j] = 0;
               else if (ov[j] && !ordy[j] && exp_cnt[j] < cmax) exp_cnt[j]++;
            end
         end
      end
   end

   initial begin
      rst = 1'b1; flush = 1'b0; cur = '0;
      for (int j = 0; j < 3; j++) begin
         iv[j] = 1'b0; ordy[j] = 1'b0; clr[j] = 1'b0; pushed[j] = 1'b0;
      end
      @(negedge clk);
      #3 chk_reset();
      @(negedge clk);
      rst = 1'b0;

      // asynchronous reset with two beats held
      send(0, 32'h100, 1'b0);
      send(0, 32'h104, 1'b0);
      iv[0] = 1'b0;
      for (int j = 0; j < 3; j++) pushed[j] = 1'b0;
      #2 rst = 1'b1;
      #1 chk_reset();
      @(negedge clk);
      rst = 1'b0;
      ordy[0] = 1'b1;
      send(0, 32'h4, 1'b0);
      iv[0] = 1'b0;
      step();

      // streaming
      for (int i = 0; i < 8; i++) send(0, 32'(i * 4), 1'b0);
      iv[0] = 1'b0;
      step();

      // back-pressure: A in main, B in skid, C held by ID
      ordy[0] = 1'b0;
      send(0, 32'hA0, 1'b0);
      send(0, 32'hB0, 1'b0);
      cur = rnd_beat(32'hC0);
      iv[0] = 1'b1;
      repeat (3) step();
      chk("c_held", 160'(pushed[0]), 160'(0));
      ordy[0] = 1'b1;
      send(0, 32'hC0, 1'b0);
      iv[0] = 1'b0;
      repeat (3) step();

      // flush with two held plus incoming beat D
      ordy[0] = 1'b0;
      send(0, 32'hE0, 1'b0);
      send(0, 32'hF0, 1'b0);
      cur = rnd_beat(32'hD0);
      iv[0] = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; iv[0] = 1'b0;
      #1 chk("flush_in_ready", 160'(irdy[0]), 160'(1));
      ordy[0] = 1'b1;
      repeat (3) step();

      // combinational ready instance with toggling out_ready
      for (int i = 0; i < 16; i++) send(1, 32'(32'h200 + i * 4), 1'b1);
      iv[1] = 1'b0; ordy[1] = 1'b1;
      repeat (3) step();

      // 3-bit counter saturation and clear
      send(2, 32'h300, 1'b0);
      iv[2] = 1'b0;
      repeat (10) step();
      #1 chk("cnt_sat", 160'(cnt_c), 160'(7));
      clr[2] = 1'b1;
      step();
      clr[2] = 1'b0;
      #1 chk("cnt_clr", 160'(cnt_c), 160'(0));
      step();
      #1 chk("cnt_after_clr", 160'(cnt_c), 160'(1));
      ordy[2] = 1'b1;
      repeat (3) step();

      // random traffic on all instances
      repeat (400) begin
         for (int j = 0; j < 3; j++) begin
            iv[j] = 1'($urandom);
            ordy[j] = ($urandom_range(0, 3) != 0);
            clr[j] = ($urandom_range(0, 15) == 0);
         end
         flush = ($urandom_range(0, 15) == 0);
         cur = rnd_beat($urandom);
         step();
      end
      flush = 1'b0;
      for (int j = 0; j < 3; j++) begin
         iv[j] = 1'b0; ordy[j] = 1'b1; clr[j] = 1'b0;
      end
      repeat (4) step();
      for (int j = 0; j < 3; j++) chk("drained", 160'(exp_q[j].size()), 160'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/idex_elastic_reg.md
# idex_elastic_reg

Parametrised ID/EX pipeline register with a valid/ready handshake, an optional skid buffer, a flush that inserts bubbles, and a saturating stall-cycle counter. It sits between the decode and execute stages. It carries the WB/M/EX control groups, PC+4, both register read values, the sign-extended immediate, and the rt/rd fields. Back-pressure from EX can stall ID without a combinational ready path when SKID=1.

## Interface
- DATA_W, 32, width of address, read-data and immediate fields
- REG_W, 5, width of rt/rd register-number fields
- WB_W, 2, width of WB control group
- M_W, 3, width of M control group
- EX_W, 4, width of EX control group
- SKID, 1, 1 = two-entry skid buffer (registered in_ready); 0 = single register, combinational in_ready
- CNT_W, 16, width of stall counter

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  ID presents a beat
- in_ready  out  1  register can accept a beat this cycle
- in_wb / in_m / in_ex  in  WB_W / M_W / EX_W  control groups
- in_address, in_readdata1, in_readdata2, in_extended  in  DATA_W each  datapath fields
- in_rt, in_rd  in  REG_W each  instruction[20:16], [15:11]
- flush  in  1  discard all held and incoming beats this edge
- out_valid  out  1  EX beat valid
- out_ready  in  1  EX consumes the beat
- out_wb / out_m / out_ex, out_address, out_readdata1, out_readdata2, out_extended, out_rt, out_rd  out  same widths as inputs
- clr_cnt  in  1  synchronous clear of stall_cnt
- stall_cnt  out  CNT_W  saturating count of stalled output cycles

## Operation
- Storage: main entry (drives out_*), plus a skid entry when SKID=1. Each entry has its own valid bit.
- Accept: in_valid && in_ready at the edge. Emit: out_valid && out_ready at the edge.
- SKID=1:
  - in_ready = !skid_valid, driven from a register.
  - Beat accepted while main is full and not emitting: goes to the skid entry.
  - On emit: main loads from skid if skid is valid, else from the input if accepting, else main goes empty.
  - Skid empties when its data moves to main.
- SKID=0:
  - in_ready = !out_valid || out_ready, combinational.
  - Main loads the input on accept.
- Ordering is strict FIFO. Beats are never dropped except by flush, and never duplicated.
- Bubble rule: whenever out_valid=0, out_wb, out_m and out_ex read 0. Datapath outputs hold their last value (don't-care).
- Flush, which has priority over everything:
  - Clears main and skid valid bits.
  - Discards any beat accepted on the same edge.
  - in_ready=1 on the next cycle.
  - stall_cnt is unaffected.
- stall_cnt:
  - Increments each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - clr_cnt has priority over increment.
- Reset:
  - All valid bits clear; all out_* = 0; stall_cnt = 0.
  - in_ready = 1 (SKID=1 register resets to 1).
  - Reset mid-transfer discards all held beats immediately (asynchronous).

## Timing
- Latency: accepted beat appears on out_* one edge after acceptance, or later if the main entry is blocked.
- Throughput: one beat per cycle when out_ready=1 continuously.
- SKID=1: in_ready deasserts the edge after the skid entry fills.
  - At most 2 beats are held.
  - No combinational path from out_ready to in_ready.
- Simultaneous accept + emit with an empty skid: the input goes directly to main, and the skid stays empty.
- Simultaneous flush + accept + emit: the emitted beat is consumed by EX, the incoming beat is discarded, and the register is empty after the edge.
- out_* change only on a clock edge or on rst assertion.

## Test plan
- Reset:
  - Stimulus: assert rst mid-cycle with 2 beats held.
  - Required: out_valid=0, all out_* = 0, stall_cnt=0 immediately; in_ready=1.
  - After release, the first beat (address=0x4) appears one edge after acceptance.
- Streaming:
  - Stimulus: out_ready=1; drive 8 back-to-back beats with address 0x0,0x4,…,0x1C.
  - Required: outputs in order, one per cycle, 1-cycle latency, stall_cnt stays 0.
- Back-pressure (SKID=1):
  - Stimulus: out_ready=0 while sending beats A, B, C.
  - Required:
    - A sits in main, B in skid; in_ready=0 the cycle after B is accepted; C is held by ID.
    - Raising out_ready yields A, B, C in order.
    - stall_cnt equals the number of out_ready=0 cycles with out_valid=1.
- Flush:
  - Stimulus: with 2 beats held, assert flush together with in_valid=1 and beat D.
  - Required: next cycle out_valid=0, out_wb/m/ex=0, D never appears, in_ready=1.
- SKID=0 instance:
  - Stimulus: toggle out_ready every cycle.
  - Required: in_ready tracks !out_valid||out_ready combinationally; no loss or duplication over 16 beats.
- Counter:
  - Stimulus: with CNT_W=3, hold a stall for 10 cycles.
  - Required: stall_cnt saturates at 7; clr_cnt during the stall gives 0, then 1 the following cycle.
